// File: rtl/tm_lif_pkg.sv
// Shared types and helpers for the time-multiplexed LIF scheduler.
package tm_lif_pkg;

  localparam int unsigned N_NEURONS_DEF = 8;
  localparam int unsigned W_DEF         = 8;
  localparam int unsigned SW_DEF        = $clog2(N_NEURONS_DEF);
  localparam int unsigned THR_RST       = 127;

  typedef enum logic [1:0] {IDLE, SCAN, STALL} sched_state_t;

  // Unsigned add clamped to max; callers size max to their own width.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

endpackage

// File: rtl/spike_fifo.sv
// Synchronous spike event FIFO; pop and push may coincide when full.
module spike_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tm_lif_sched.sv
// Round-robin LIF neuron scheduler: per-slot state banks, one shared update
// datapath per cycle, spike events queued for the routing fabric.
module tm_lif_sched
  import tm_lif_pkg::*;
#(
  parameter int unsigned N_NEURONS  = N_NEURONS_DEF,
  parameter int unsigned W          = W_DEF,
  parameter int unsigned REFRACT    = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned SW        = $clog2(N_NEURONS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          cfg_we,
  input  logic [SW-1:0] cfg_addr,
  input  logic [W-1:0]  cfg_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] in_slot,
  input  logic [W-1:0]  in_current,
  output logic          spk_valid,
  input  logic          spk_ready,
  output logic [SW-1:0] spk_slot,
  output logic          frame_done,
  output logic [SW-1:0] cur_slot
);

  localparam logic [31:0] MAXV = (32'd1 << W) - 32'd1;

  sched_state_t  state_q;
  logic [SW-1:0] slot_q;
  logic          in_ready_q, frame_done_q;
  logic [W-1:0]  v_q   [N_NEURONS];
  logic [W-1:0]  acc_q [N_NEURONS];
  logic [W-1:0]  thr_q [N_NEURONS];
  logic [2:0]    rc_q  [N_NEURONS];

  logic          active, refr, fire, blocked, do_update, in_fire;
  logic          fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [W-1:0]  vn;

  // A firing slot may proceed into a full FIFO only if a pop frees a place this cycle.
  always_comb begin
    active    = (state_q != IDLE);
    refr      = (rc_q[slot_q] != 3'd0);
    vn        = W'(sat_add(32'(acc_q[slot_q]), 32'(v_q[slot_q] >> 1), MAXV));
    fire      = active && !refr && (vn >= thr_q[slot_q]);
    fifo_pop  = !fifo_empty && spk_ready;
    blocked   = fire && fifo_full && !fifo_pop;
    do_update = active && !blocked;
    fifo_push = fire && !blocked;
    in_fire   = in_valid && in_ready_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      in_ready_q   <= 1'b0;
      frame_done_q <= 1'b0;
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        v_q[i]   <= '0;
        acc_q[i] <= '0;
        thr_q[i] <= W'(THR_RST);
        rc_q[i]  <= '0;
      end
    end else begin
      in_ready_q   <= 1'b1;
      frame_done_q <= 1'b0;
      if (cfg_we) thr_q[cfg_addr] <= cfg_data;
      if (in_fire)
        acc_q[in_slot] <= W'(sat_add(32'(acc_q[in_slot]), 32'(in_current), MAXV));
      if (do_update) begin
        if (refr) begin
          v_q[slot_q]  <= '0;
          rc_q[slot_q] <= rc_q[slot_q] - 3'd1;
        end else if (fire) begin
          v_q[slot_q]  <= '0;
          rc_q[slot_q] <= 3'(REFRACT);
        end else begin
          v_q[slot_q]  <= vn;
        end
        // Colliding input overrides the clear so it lands in the next frame.
        acc_q[slot_q] <= (in_fire && in_slot == slot_q) ? in_current : '0;
        if (slot_q == SW'(N_NEURONS - 1)) begin
          slot_q       <= '0;
          frame_done_q <= 1'b1;
          state_q      <= run ? SCAN : IDLE;
        end else begin
          slot_q  <= slot_q + 1'b1;
          state_q <= SCAN;
        end
      end else if (active) begin
        state_q <= STALL;
      end else if (run) begin
        state_q <= SCAN;
      end
    end
  end

  spike_fifo #(
    .DEPTH(FIFO_DEPTH),
    .DW   (SW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(slot_q),
    .pop      (fifo_pop),
    .pop_data (spk_slot),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign in_ready   = in_ready_q;
  assign spk_valid  = !fifo_empty;
  assign frame_done = frame_done_q;
  assign cur_slot   = slot_q;

endmodule

// File: tb/tb_tm_lif_sched.sv
// Randomized bench for tm_lif_sched against a frame-level behavioural neuron model.
module tb_tm_lif_sched;

  localparam int unsigned SW   = tm_lif_pkg::SW_DEF;
  localparam int unsigned NN   = 8;
  localparam int unsigned REFR = 2;
  localparam int unsigned FD   = 4;
  localparam int unsigned VMAX = 255;

  logic          clk = 1'b0;
  logic          rst, run, cfg_we, in_valid, spk_ready;
  logic [SW-1:0] cfg_addr, in_slot;
  logic [7:0]    cfg_data, in_current;
  logic          in_ready, spk_valid, frame_done;
  logic [SW-1:0] spk_slot, cur_slot;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Behavioural model state
  int unsigned m_v[NN], m_acc[NN], m_thr[NN], m_rc[NN];
  int unsigned m_pos;
  bit          m_scan, m_fd, m_inrdy;
  int unsigned m_q[$];

  tm_lif_sched #(
    .N_NEURONS (NN),
    .W         (8),
    .REFRACT   (REFR),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_slot   (in_slot),
    .in_current(in_current),
    .spk_valid (spk_valid),
    .spk_ready (spk_ready),
    .spk_slot  (spk_slot),
    .frame_done(frame_done),
    .cur_slot  (cur_slot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NN; i++) begin
      m_v[i] = 0; m_acc[i] = 0; m_thr[i] = 127; m_rc[i] = 0;
    end
    m_pos = 0; m_scan = 0; m_fd = 0; m_inrdy = 0;
    m_q.delete();
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_next();
    bit pop, accept, upd, fires;
    int unsigned k, vn, s;
    k = m_pos; vn = 0; fires = 0; upd = 0;
    pop    = (m_q.size() != 0) && spk_ready;
    accept = in_valid && m_inrdy;
    m_fd   = 0;
    if (m_scan) begin
      if (m_rc[k] == 0) begin
        vn = m_acc[k] + m_v[k] / 2;
        if (vn > VMAX) vn = VMAX;
        fires = (vn >= m_thr[k]);
      end
      upd = !(fires && m_q.size() == FD && !pop);
    end
    if (pop) void'(m_q.pop_front());
    if (upd) begin
      if (m_rc[k] != 0) begin m_v[k] = 0; m_rc[k] = m_rc[k] - 1; end
      else if (fires) begin m_v[k] = 0; m_rc[k] = REFR; m_q.push_back(k); end
      else m_v[k] = vn;
      m_acc[k] = 0;
    end
    if (accept) begin
      s = m_acc[in_slot] + in_current;
      m_acc[in_slot] = (s > VMAX) ? VMAX : s;
    end
    if (cfg_we) m_thr[cfg_addr] = cfg_data;
    if (upd) begin
      if (k == NN - 1) begin m_pos = 0; m_fd = 1; m_scan = run; end
      else m_pos = m_pos + 1;
    end else if (!m_scan) begin
      m_scan = run;
    end
    m_inrdy = 1;
  endtask

  task automatic step();
    @(negedge clk);
    check("cur_slot", 32'(cur_slot), m_pos);
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("in_ready", 32'(in_ready), 32'(m_inrdy));
    check("spk_valid", 32'(spk_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("spk_slot", 32'(spk_slot), m_q[0]);
    for (int i = 0; i < NN; i++) check("v", 32'(dut.v_q[i]), m_v[i]);
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_spk_valid", 32'(spk_valid), 0);
    check("rst_spk_slot", 32'(spk_slot), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_cur_slot", 32'(cur_slot), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    cfg_we = 0; cfg_addr = '0; cfg_data = '0;
    in_valid = 0; in_slot = '0; in_current = '0;
  endtask

  initial begin
    run = 0; spk_ready = 1;
    idle_inputs();
    do_reset();

    // Free-running sweep with no input
    run = 1;
    repeat (24) step();

    // Slot 3 gets 200 every frame: fires then stays refractory for two frames
    repeat (48) begin
      in_valid = (m_pos == 1); in_slot = 3'd3; in_current = 8'd200;
      step();
    end

    // Slot 5 gets 64 every frame: fires on the seventh frame
    repeat (64) begin
      in_valid = (m_pos == 0); in_slot = 3'd5; in_current = 8'd64;
      step();
    end

    // Accumulator saturation on slot 0 and an input colliding with slot 2's update
    repeat (16) begin
      in_valid = (m_pos == 2) || (m_pos == 3) || (m_pos == 5);
      in_slot  = (m_pos == 2) ? 3'd2 : 3'd0;
      in_current = (m_pos == 2) ? 8'd30 : (m_pos == 3) ? 8'd255 : 8'd10;
      step();
    end
    idle_inputs();

    // Backpressure: every slot fires while the consumer is stalled
    do_reset();
    run = 0;
    for (int i = 0; i < NN; i++) begin
      cfg_we = 1; cfg_addr = 3'(i); cfg_data = 8'd1;
      step();
    end
    cfg_we = 0;
    for (int i = 0; i < NN; i++) begin
      in_valid = 1; in_slot = 3'(i); in_current = 8'd50;
      step();
    end
    idle_inputs();
    spk_ready = 0; run = 1;
    repeat (20) step();
    spk_ready = 1;
    repeat (30) step();

    // Random traffic
    repeat (600) begin
      in_valid   = ($urandom_range(1) == 1);
      in_slot    = 3'($urandom_range(NN - 1));
      in_current = 8'($urandom_range(255));
      cfg_we     = ($urandom_range(15) == 0);
      cfg_addr   = 3'($urandom_range(NN - 1));
      cfg_data   = 8'($urandom_range(255));
      spk_ready  = ($urandom_range(3) != 0);
      if ($urandom_range(39) == 0) run = !run;
      step();
    end
    idle_inputs();

    // Threshold write then reset in the middle of a frame
    run = 1; spk_ready = 0;
    cfg_we = 1; cfg_addr = 3'd1; cfg_data = 8'd10;
    step();
    cfg_we = 0;
    repeat (3) begin
      in_valid = 1; in_slot = 3'($urandom_range(NN - 1)); in_current = 8'd255;
      step();
    end
    idle_inputs();
    do_reset();
    check("thr1_after_rst", 32'(dut.thr_q[1]), m_thr[1]);
    spk_ready = 1;
    repeat (12) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tm_lif_sched.md
# tm_lif_sched

Time-multiplexed scheduler and state store for a bank of leaky integrate-and-fire neurons sharing one LIF update datapath. It accumulates input current per neuron slot and sweeps the slots round-robin, one update per cycle. Each update applies leak, integration, threshold compare, reset and refractory handling. Spike events are queued in a small FIFO for a downstream consumer. It sits between the input-current requesters and the spike routing fabric and owns all per-neuron configuration.

## Interface

Parameters:
- N_NEURONS, 8: neuron slots; power of two; slot index width SW = log2(N_NEURONS).
- W, 8: membrane, current and threshold width.
- REFRACT, 2: refractory cycles (frames) after a spike, 0..7.
- FIFO_DEPTH, 4: spike event FIFO depth, power of two.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- run  in  1  level; 1 = sweep slots, 0 = hold at frame boundary.
- cfg_we  in  1  threshold write strobe.
- cfg_addr  in  SW  slot being configured.
- cfg_data  in  W  threshold value.
- in_valid  in  1  input current offered.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_slot  in  SW  target slot.
- in_current  in  W  current to add.
- spk_valid  out  1  spike event available.
- spk_ready  in  1  consumer accepts event.
- spk_slot  out  SW  slot that fired.
- frame_done  out  1  one-cycle pulse after slot N_NEURONS-1 is updated.
- cur_slot  out  SW  slot updated this cycle (debug).

## Operation

- Per slot: membrane v (reset 0), accumulator acc (reset 0), threshold thr (reset 127), refractory count rc (3 bits, reset 0).
- Input: an accepted beat does acc[in_slot] = sat(acc + in_current), saturating at 2^W-1.
- Update of slot k: vn = sat(acc[k] + (v[k] >> 1)).
  - If vn >= thr[k]: push k into the FIFO, v[k] = 0, rc[k] = REFRACT.
  - Otherwise: v[k] = vn.
  - acc[k] is cleared in both cases.
- Refractory slot (rc[k] != 0): v held 0, acc[k] discarded, no compare, rc[k] decremented.
- Input collision: an input to slot k in the same cycle k is updated lands in the next frame. The update consumes the old acc and acc[k] becomes sat(in_current).
- Config write: takes effect from the next update of that slot. A write to the slot being updated that cycle applies next frame.
- FSM:
  - IDLE: run=0; cur_slot=0. Goes to SCAN when run=1.
  - SCAN: one slot per cycle; cur_slot increments and wraps N_NEURONS-1 to 0. At the wrap, frame_done pulses and the FSM goes to IDLE if run=0, else stays in SCAN.
  - STALL: entered when the slot about to be updated would fire and the FIFO is full. No update, cur_slot held, all slot state held. Returns to SCAN on the first cycle the FIFO has space.
- run deasserted mid-frame: the frame completes before IDLE.
- in_ready: registered, 0 in reset, 1 from the first cycle after rst deasserts. Accumulation never backpressures.
- FIFO: spk_valid = !empty; spk_slot = head entry; pop on spk_valid && spk_ready. Push and pop in the same cycle when full is allowed, and no stall occurs.

## Timing

- Output reset values:
  - in_ready = 0.
  - spk_valid = 0.
  - spk_slot = 0.
  - frame_done = 0.
  - cur_slot = 0.
- Update is single-cycle. A spike from an update at edge t is visible as spk_valid after edge t (next cycle) when the FIFO was empty.
- A frame takes N_NEURONS cycles without stalls. frame_done is asserted in the cycle after the last update.
- Input accepted at edge t is usable by an update at edge t+1 or later.
- Reset mid-frame: all state returns to reset values immediately. FIFO contents and pending spikes are lost.

## Structure

- Shared package tm_lif_pkg: W, N_NEURONS, SW defaults; FSM state enum {IDLE, SCAN, STALL}; threshold reset constant 127; saturating-add function.
- One sub-module: spike_fifo (parameterised synchronous FIFO, DEPTH x SW, full/empty flags, same clk/rst).
- Slot arrays are register banks inside tm_lif_sched.

## Test plan

- Reset, then run=1 with no input: v stays 0, no spikes, frame_done every 8 cycles, cur_slot sequence 0..7..0.
- Slot 3 gets current 200 before the frame, thr 127: slot 3 fires once, spk_slot=3, v[3]=0. With REFRACT=2 it stays silent for 2 frames even with current 200 each frame.
- Slot 5 gets current 64 per frame, thr 127: v goes 64, 96, 112, 120, 124, 126, 127; fires on the 7th frame.
- Input 255 then 10 to slot 0 in one frame: acc saturates at 255. Input to slot 2 in the same cycle slot 2 is updated: counted next frame only.
- spk_ready=0 with all slots above threshold: 4 events queue, STALL at the 5th firing slot, cur_slot frozen. Releasing spk_ready drains events in order 0,1,2,3,4... with no loss.
- cfg write thr[1]=10 and assert rst mid-frame: all outputs return to reset values, thr[1] returns to 127, FIFO empties.
